ecc_scrub_ctrl: RTL



---
 rtl/ecc_scrub_pkg.sv | 27 ++
 rtl/ecc_scrub_ctrl_if.sv | 30 +++
 rtl/ecc_sat_cnt.sv | 37 +++
 rtl/ecc_scrub_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg
//   Shared types for the cache ECC scrub controller.
//   - scrub_ctrl_state_e : scheduler FSM encoding (Idle / Wait / Trigger)
//   - scrub_stats_t      : the three event/sweep counters plus the sticky
//                          error log. Fields use the widest supported size
//                          (counters up to 32 bits, addresses up to 16 bits).
//                          Narrower instances zero-extend into the fields.
package ecc_scrub_pkg;

  localparam int unsigned StatsCntWidth  = 32;
  localparam int unsigned StatsAddrWidth = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StTrigger = 2'd2
  } scrub_ctrl_state_e;

  typedef struct packed {
    logic [StatsCntWidth-1:0]  corr_cnt;
    logic [StatsCntWidth-1:0]  uncorr_cnt;
    logic [StatsCntWidth-1:0]  sweep_cnt;
    logic                      err_valid;
    logic [StatsAddrWidth-1:0] err_add;
  } scrub_stats_t;

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if
//   Handshake between the scrub controller and the ECC scrubber.
//   - scrub_trigger : controller -> scrubber, start/hold a line scrub
//   - scrub_done    : scrubber -> controller, one-cycle pulse in the final
//                     Write cycle of a line
//   - bit_corrected : scrubber -> controller, corrected-error event pulse
//   - uncorrectable : scrubber -> controller, uncorrectable-error event pulse
//   Modports: master = controller side, slave = scrubber side.
interface ecc_scrub_ctrl_if;

  logic scrub_trigger;
  logic scrub_done;
  logic bit_corrected;
  logic uncorrectable;

  modport master (
    output scrub_trigger,
    input  scrub_done,
    input  bit_corrected,
    input  uncorrectable
  );

  modport slave (
    input  scrub_trigger,
    output scrub_done,
    output bit_corrected,
    output uncorrectable
  );

endinterface

// File: rtl/ecc_sat_cnt.sv
// ecc_sat_cnt
//   Saturating up-counter with synchronous clear. A clear and an increment
//   in the same cycle leave the counter at 1 (the increment lands after the
//   clear). The counter sticks at all-ones.
//   Ports:
//     clk_i  : clock
//     rst_i  : asynchronous active-high reset
//     clr_i  : synchronous clear
//     inc_i  : increment request
//     cnt_o  : registered count
module ecc_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= Width'(inc_i);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Scheduler and event logger for the cache ECC scrubber. Paces scrub
//   passes with a programmable idle interval, tracks the scrubbed line with a
//   shadow address, counts corrected/uncorrectable events and full-bank
//   sweeps, and logs the first uncorrectable line.
//   Build option: define ECC_SCRUB_IRQ_EN to get the registered interrupt;
//   without it irq_o is tied low and threshold_i is ignored.
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-high reset
//     enable_i       : scheduling enable (a pass in flight always completes)
//     interval_i     : idle cycles between passes, sampled on entry to Wait
//     threshold_i    : corrected-count interrupt threshold, 0 = disabled
//     clear_i        : clears counters, error log and irq
//     scrub_if       : scrubber handshake (master side)
//     shadow_add_o   : line being, or next to be, scrubbed
//     corr_cnt_o     : saturating corrected-event count
//     uncorr_cnt_o   : saturating uncorrectable-event count
//     sweep_cnt_o    : saturating completed-sweep count
//     err_valid_o    : sticky, first uncorrectable event seen
//     err_add_o      : shadow address captured with err_valid_o
//     irq_o          : registered level interrupt, held until clear_i
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter  int unsigned BankSize      = 256,
  parameter  int unsigned IntervalWidth = 16,
  parameter  int unsigned CntWidth      = 16,
  localparam int unsigned AddrWidth     = $clog2(BankSize)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic [CntWidth-1:0]      threshold_i,
  input  logic                     clear_i,
  ecc_scrub_ctrl_if.master         scrub_if,
  output logic [AddrWidth-1:0]     shadow_add_o,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic [CntWidth-1:0]      sweep_cnt_o,
  output logic                     err_valid_o,
  output logic [AddrWidth-1:0]     err_add_o,
  output logic                     irq_o
);

  scrub_ctrl_state_e        state_q, state_d;
  logic [IntervalWidth-1:0] wait_cnt_q;
  logic [AddrWidth-1:0]     shadow_q;
  logic                     shadow_wrap;
  logic                     err_valid_q;
  logic [AddrWidth-1:0]     err_add_q;
  logic [CntWidth-1:0]      corr_cnt, uncorr_cnt, sweep_cnt;
  scrub_stats_t             stats;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d                = state_q;
    scrub_if.scrub_trigger = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StWait;
      end
      StWait: begin
        if (!enable_i)               state_d = StIdle;
        else if (wait_cnt_q == '0)   state_d = StTrigger;
      end
      StTrigger: begin
        scrub_if.scrub_trigger = 1'b1;
        // Disabling never aborts a pass; only the return path changes.
        if (scrub_if.scrub_done) state_d = enable_i ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Interval down-counter: reloaded on every entry into Wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if ((state_d == StWait) && (state_q != StWait)) begin
      wait_cnt_q <= interval_i;
    end else if ((state_q == StWait) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - IntervalWidth'(1);
    end
  end

  // ------------------------------------------------------ shadow address
  assign shadow_wrap = scrub_if.scrub_done && (shadow_q == AddrWidth'(BankSize - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else if (scrub_if.scrub_done) begin
      shadow_q <= shadow_wrap ? '0 : shadow_q + AddrWidth'(1);
    end
  end

  // ------------------------------------------------------------- counters
  ecc_sat_cnt #(.Width(CntWidth)) u_corr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (scrub_if.bit_corrected),
    .cnt_o (corr_cnt)
  );

  ecc_sat_cnt #(.Width(CntWidth)) u_uncorr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (scrub_if.uncorrectable),
    .cnt_o (uncorr_cnt)
  );

  ecc_sat_cnt #(.Width(CntWidth)) u_sweep_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (shadow_wrap),
    .cnt_o (sweep_cnt)
  );

  // ------------------------------------------------------------ error log
  // The captured address is the pre-increment shadow, i.e. the line whose
  // scrub raised the event. An event coinciding with clear is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_add_q   <= '0;
    end else if (clear_i) begin
      err_valid_q <= scrub_if.uncorrectable;
      err_add_q   <= scrub_if.uncorrectable ? shadow_q : '0;
    end else if (scrub_if.uncorrectable && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_add_q   <= shadow_q;
    end
  end

  // ------------------------------------------------------------ interrupt
`ifdef ECC_SCRUB_IRQ_EN
  logic irq_q;
  logic thr_hit;

  assign thr_hit = (threshold_i != '0) && (corr_cnt == threshold_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else if (clear_i) begin
      irq_q <= scrub_if.uncorrectable;
    end else if (scrub_if.uncorrectable || thr_hit) begin
      irq_q <= 1'b1;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold_i;
  assign irq_o            = 1'b0;
`endif

  // -------------------------------------------------------------- outputs
  always_comb begin
    stats            = '0;
    stats.corr_cnt   = StatsCntWidth'(corr_cnt);
    stats.uncorr_cnt = StatsCntWidth'(uncorr_cnt);
    stats.sweep_cnt  = StatsCntWidth'(sweep_cnt);
    stats.err_valid  = err_valid_q;
    stats.err_add    = StatsAddrWidth'(err_add_q);
  end

  assign shadow_add_o = shadow_q;
  assign corr_cnt_o   = CntWidth'(stats.corr_cnt);
  assign uncorr_cnt_o = CntWidth'(stats.uncorr_cnt);
  assign sweep_cnt_o  = CntWidth'(stats.sweep_cnt);
  assign err_valid_o  = stats.err_valid;
  assign err_add_o    = AddrWidth'(stats.err_add);

endmodule
